// File: rtl/serial_subtractor_pkg.sv
// Shared state encoding and the single-bit borrow equation used by the serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ssub_state_e;

  // Borrow generated by one bit position of a - b - bin.
  function automatic logic sub_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Combinational one-bit full subtractor; port order mirrors the full_adder cell.
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = sub_borrow(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - BIN computed LSB first, one bit per clock,
// reusing a single full_subtractor with a registered borrow between cycles.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  ssub_state_e      state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             d_s;
  logic             bo_s;
  logic [WIDTH-1:0] res_shift_s;

  full_subtractor u_fs (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .bin  (br_q),
    .diff (d_s),
    .bout (bo_s)
  );

  // Result register with the current difference bit inserted at the MSB.
  always_comb begin
    res_shift_s            = res_q >> 1'b1;
    res_shift_s[WIDTH-1]   = d_s;
  end

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          br_d    = bin;
          cnt_d   = '0;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        ra_d  = ra_q >> 1'b1;
        rb_d  = rb_q >> 1'b1;
        br_d  = bo_s;
        res_d = res_shift_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Final bit: publish the whole result at once so partial state never leaks.
          state_d = ST_DONE;
          done_d  = 1'b1;
          diff_d  = res_shift_s;
          bout_d  = bo_s;
          ovf_d   = (amsb_q != bmsb_q) && (d_s != amsb_q);
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 vector table plus busy/back-to-back/reset
// sequences, and a WIDTH=1 instance checked against the full-subtractor truth table.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = 8'h00;
  logic [7:0] b8 = 8'h00;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = 1'b0;
  logic [0:0] b1 = 1'b0;
  logic       bin1 = 1'b0;
  logic       busy1, done1, bout1, ovf1;
  logic [0:0] diff1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec8_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one WIDTH=8 operation; returns the cycle of done (0 = timeout) and busy count.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                     output int lat, output int nbusy);
    @(negedge clk);
    a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; nbusy = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy8) nbusy++;
      if (done8) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic op1(input logic av, input logic bv, input logic bi, output int lat);
    @(negedge clk);
    a1 = av; b1 = bv; bin1 = bi; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      if (done1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  vec8_t vt [10];
  logic [2:0] tt1 [8];

  initial begin
    int lat, nb, k, bad, cyc, last_done;
    logic [7:0] held;
    logic [7:0] exp_b2b [3];

    vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vt[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vt[8] = '{8'h55, 8'hAA, 1'b0, 8'hAB, 1'b1, 1'b1};
    vt[9] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};

    // {diff, bout, ovf} indexed by {a, b, bin}
    tt1[0] = 3'b000; tt1[1] = 3'b110; tt1[2] = 3'b111; tt1[3] = 3'b010;
    tt1[4] = 3'b100; tt1[5] = 3'b001; tt1[6] = 3'b000; tt1[7] = 3'b110;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_diff", {24'd0, diff8}, 32'd0);
    check("rst_bout_ovf", {30'd0, bout8, ovf8}, 32'd0);
    check("rst_w1", {28'd0, busy1, done1, diff1, bout1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      op8(vt[i].a, vt[i].b, vt[i].bin, lat, nb);
      check($sformatf("v%0d_latency", i), lat, 32'd9);
      check($sformatf("v%0d_busy_cycles", i), nb, 32'd8);
      check($sformatf("v%0d_diff", i), {24'd0, diff8}, {24'd0, vt[i].diff});
      check($sformatf("v%0d_bout", i), {31'd0, bout8}, {31'd0, vt[i].bout});
      check($sformatf("v%0d_ovf", i), {31'd0, ovf8}, {31'd0, vt[i].ovf});
    end
    @(negedge clk);
    check("hold_after_done", {20'd0, busy8, done8, diff8, bout8, ovf8}, {20'd0, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0});

    // Start while busy is ignored
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        a8 = 8'h11; b8 = 8'h11; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      if (done8) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check("busy_start_latency", lat, 32'd9);
    check("busy_start_diff", {24'd0, diff8}, 32'h02);
    @(negedge clk);
    check("busy_start_not_queued", {30'd0, busy8, done8}, 32'd0);

    // Start held high: back-to-back ops, outputs change only on done
    exp_b2b[0] = 8'h02; exp_b2b[1] = 8'h7F; exp_b2b[2] = 8'h7F;
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01;
    held = diff8;
    k = 0; bad = 0; last_done = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (done8) begin
        check($sformatf("b2b_spacing%0d", k), cyc - last_done, 32'd9);
        check($sformatf("b2b_diff%0d", k), {24'd0, diff8}, {24'd0, exp_b2b[k]});
        held = diff8;
        last_done = cyc;
        k++;
        if (k == 3) break;
      end else if (diff8 !== held || !busy8) begin
        bad++;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    check("b2b_done_count", k, 32'd3);
    check("b2b_hold_between", bad, 32'd0);
    @(negedge clk);
    check("b2b_stops", {30'd0, busy8, done8}, 32'd0);

    // Reset in the middle of SHIFT
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {21'd0, busy8, done8, diff8, bout8, ovf8}, 32'd0);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) bad++;
    end
    rst_n = 1'b1;
    check("midrst_no_done", bad, 32'd0);
    op8(8'h03, 8'h05, 1'b0, lat, nb);
    check("postrst_latency", lat, 32'd9);
    check("postrst_result", {22'd0, diff8, bout8, ovf8}, {22'd0, 8'hFE, 1'b1, 1'b0});

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      op1(idx[2], idx[1], idx[0], lat);
      check($sformatf("w1_%0d_latency", i), lat, 32'd2);
      check($sformatf("w1_%0d_result", i), {29'd0, diff1, bout1, ovf1}, {29'd0, tt1[i]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
